// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control sequencer with multi-cycle execute, hold/stall and ready gating.
// Interrupt entry between instructions is built only when SEQ_IRQ_EN is defined.
module instr_sequencer #(
  parameter int OPCODE_W   = 8,
  parameter int CYCLE_W    = 2,
  parameter int IRQ_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ready,
  input  logic                hold,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [CYCLE_W-1:0]  exec_cycles,
  input  logic                irq_req,
  output logic                fetch,
  output logic                decode,
  output logic                execute,
  output logic                int_entry,
  output logic                irq_ack,
  output logic                instr_done,
  output logic [OPCODE_W-1:0] opcode_q,
  output logic [CYCLE_W-1:0]  cyc_left,
  output logic [2:0]          dbg_state
);

  localparam int IRQ_W = (IRQ_CYCLES > 1) ? $clog2(IRQ_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_INIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_IRQ    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_d;
  logic [CYCLE_W-1:0]    cyc_left_q, cyc_left_d;

  // ready is a level qualifier with no valid side: FETCH completes, and each EXEC
  // cycle retires, only on a clock where ready=1 and hold=0.
`ifdef SEQ_IRQ_EN
  logic [IRQ_W-1:0]      irq_cnt_q, irq_cnt_d;
`else
  logic [IRQ_W-1:0]      unused_irq_cfg;
  assign unused_irq_cfg = IRQ_W'(IRQ_CYCLES - 1) ^ {IRQ_W{irq_req}};
`endif

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    cyc_left_d = cyc_left_q;
    instr_done = 1'b0;
    irq_ack    = 1'b0;
`ifdef SEQ_IRQ_EN
    irq_cnt_d  = irq_cnt_q;
`endif
    if (!hold) begin
      case (state_q)
        S_START:  state_d = S_INIT;
        S_INIT:   state_d = S_FETCH;
        S_FETCH: begin
          if (ready) begin
            opcode_d = opcode;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          cyc_left_d = exec_cycles;
          state_d    = S_EXEC;
        end
        S_EXEC: begin
          if (ready) begin
            if (cyc_left_q != '0) begin
              cyc_left_d = cyc_left_q - CYCLE_W'(1);
            end else begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
`ifdef SEQ_IRQ_EN
              // Interrupts are only considered at the instruction boundary.
              if (irq_req) begin
                state_d   = S_IRQ;
                irq_cnt_d = IRQ_W'(IRQ_CYCLES - 1);
              end
`endif
            end
          end
        end
`ifdef SEQ_IRQ_EN
        S_IRQ: begin
          irq_ack = (irq_cnt_q == IRQ_W'(IRQ_CYCLES - 1));
          if (irq_cnt_q == '0) begin
            state_d = S_FETCH;
          end else begin
            irq_cnt_d = irq_cnt_q - IRQ_W'(1);
          end
        end
`endif
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_START;
      opcode_q   <= '0;
      cyc_left_q <= '0;
`ifdef SEQ_IRQ_EN
      irq_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      cyc_left_q <= cyc_left_d;
`ifdef SEQ_IRQ_EN
      irq_cnt_q  <= irq_cnt_d;
`endif
    end
  end

  assign fetch     = (state_q == S_FETCH);
  assign decode    = (state_q == S_DECODE);
  assign execute   = (state_q == S_EXEC);
`ifdef SEQ_IRQ_EN
  assign int_entry = (state_q == S_IRQ);
`else
  assign int_entry = 1'b0;
`endif
  assign cyc_left  = cyc_left_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized instruction
// streams checked against a phase-level model (stall/hold/irq aware when SEQ_IRQ_EN is set).
module tb_instr_sequencer;

  localparam int OPCODE_W   = 8;
  localparam int CYCLE_W    = 2;
  localparam int IRQ_CYCLES = 2;
`ifdef SEQ_IRQ_EN
  localparam int NIRQ = IRQ_CYCLES;
`else
  localparam int NIRQ = 0;
`endif

  localparam logic [2:0] ST_START  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_IRQ    = 3'd5;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                ready = 1'b0;
  logic                hold = 1'b0;
  logic                irq_req = 1'b0;
  logic [OPCODE_W-1:0] opcode = '0;
  logic [CYCLE_W-1:0]  exec_cycles = '0;
  logic                fetch, decode, execute, int_entry, irq_ack, instr_done;
  logic [OPCODE_W-1:0] opcode_q;
  logic [CYCLE_W-1:0]  cyc_left;
  logic [2:0]          dbg_state;

  int total = 0;
  int bad   = 0;

  instr_sequencer #(
    .OPCODE_W(OPCODE_W), .CYCLE_W(CYCLE_W), .IRQ_CYCLES(IRQ_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready), .hold(hold), .opcode(opcode),
    .exec_cycles(exec_cycles), .irq_req(irq_req), .fetch(fetch), .decode(decode),
    .execute(execute), .int_entry(int_entry), .irq_ack(irq_ack), .instr_done(instr_done),
    .opcode_q(opcode_q), .cyc_left(cyc_left), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // {fetch, decode, execute, int_entry} expected for a phase
  function automatic logic [3:0] strobes_for(input logic [2:0] st);
    case (st)
      ST_FETCH:  return 4'b1000;
      ST_DECODE: return 4'b0100;
      ST_EXEC:   return 4'b0010;
      ST_IRQ:    return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  // Apply inputs for the next rising edge; outputs are then observed mid-cycle.
  task automatic drive(input logic r, input logic h, input logic irq,
                       input logic [OPCODE_W-1:0] op, input logic [CYCLE_W-1:0] ec);
    @(negedge clock);
    ready = r; hold = h; irq_req = irq; opcode = op; exec_cycles = ec;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ready = 1'b1; opcode = 8'h5C; exec_cycles = 2'd3;
    @(negedge clock); @(negedge clock); #1;
    total++;
    if (dbg_state !== ST_START) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_START);
    end
    total++;
    if ({fetch, decode, execute, int_entry, irq_ack, instr_done, opcode_q, cyc_left} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: strobes=%b ack=%b done=%b opcode_q=%h cyc_left=%0d want all 0",
               {fetch, decode, execute, int_entry}, irq_ack, instr_done, opcode_q, cyc_left);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_st [0:4];
    exp_st = '{ST_START, ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC};
    ready = 1'b1; hold = 1'b0; irq_req = 1'b0; opcode = 8'hA5; exec_cycles = 2'd0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) drive(1'b1, 1'b0, 1'b0, 8'hA5, 2'd0);
      total++;
      if (dbg_state !== exp_st[i] || {fetch, decode, execute, int_entry} !== strobes_for(exp_st[i]) ||
          instr_done !== (i == 4) || opcode_q !== ((i >= 3) ? 8'hA5 : 8'h00)) begin
        bad++;
        $display("FAIL basic cyc%0d: state=%0d strobes=%b done=%b opcode_q=%h want state=%0d strobes=%b done=%b opcode_q=%h",
                 i, dbg_state, {fetch, decode, execute, int_entry}, instr_done, opcode_q, exp_st[i],
                 strobes_for(exp_st[i]), (i == 4), ((i >= 3) ? 8'hA5 : 8'h00));
      end
    end
  endtask

  task automatic test_multi_exec();
    logic [2:0] es;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h3C, 2'd3);
      es = (i == 0) ? ST_FETCH : (i == 1) ? ST_DECODE : ST_EXEC;
      total++;
      if (dbg_state !== es || {fetch, decode, execute, int_entry} !== strobes_for(es) ||
          instr_done !== (i == 5) || (i >= 2 && cyc_left !== 2'(5 - i)) ||
          (i >= 1 && opcode_q !== 8'h3C)) begin
        bad++;
        $display("FAIL multi_exec cyc%0d: state=%0d done=%b cyc_left=%0d opcode_q=%h want state=%0d done=%b cyc_left=%0d opcode_q=3c",
                 i, dbg_state, instr_done, cyc_left, opcode_q, es, (i == 5), 2'(5 - i));
      end
    end
  endtask

  task automatic test_stall();
    logic       rdy [0:6];
    logic [2:0] est [0:6];
    logic [1:0] ecl [0:6];
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    est = '{ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_EXEC, ST_EXEC, ST_EXEC};
    ecl = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    for (int i = 0; i < 7; i++) begin
      drive(rdy[i], 1'b0, 1'b0, rdy[i] ? 8'h5A : 8'hFF, 2'd1);
      total++;
      if (dbg_state !== est[i] || instr_done !== (i == 6) || (i >= 4 && cyc_left !== ecl[i]) ||
          (i >= 3 && opcode_q !== 8'h5A)) begin
        bad++;
        $display("FAIL stall cyc%0d: state=%0d done=%b cyc_left=%0d opcode_q=%h want state=%0d done=%b cyc_left=%0d opcode_q=5a",
                 i, dbg_state, instr_done, cyc_left, opcode_q, est[i], (i == 6), ecl[i]);
      end
    end
  endtask

  task automatic test_irq();
    logic [2:0] es;
    for (int i = 0; i < 4 + NIRQ; i++) begin
      drive(1'b1, 1'b0, (i >= 1 && i <= 3), 8'h42, 2'd1);
      es = (i == 0) ? ST_FETCH : (i == 1) ? ST_DECODE : (i <= 3) ? ST_EXEC : ST_IRQ;
      total++;
      if (dbg_state !== es || {fetch, decode, execute, int_entry} !== strobes_for(es) ||
          instr_done !== (i == 3) || irq_ack !== (i == 4)) begin
        bad++;
        $display("FAIL irq cyc%0d: state=%0d strobes=%b done=%b ack=%b want state=%0d strobes=%b done=%b ack=%b",
                 i, dbg_state, {fetch, decode, execute, int_entry}, instr_done, irq_ack, es,
                 strobes_for(es), (i == 3), (i == 4));
      end
    end
  endtask

  task automatic test_hold_irq();
    logic [2:0] es;
    for (int i = 0; i < 6 + NIRQ; i++) begin
      drive(1'b1, (i >= 2 && i <= 4), 1'b1, 8'h77, 2'd0);
      es = (i == 0) ? ST_FETCH : (i == 1) ? ST_DECODE : (i <= 5) ? ST_EXEC : ST_IRQ;
      total++;
      if (dbg_state !== es || {fetch, decode, execute, int_entry} !== strobes_for(es) ||
          instr_done !== (i == 5) || irq_ack !== (i == 6)) begin
        bad++;
        $display("FAIL hold_irq cyc%0d: state=%0d strobes=%b done=%b ack=%b want state=%0d strobes=%b done=%b ack=%b",
                 i, dbg_state, {fetch, decode, execute, int_entry}, instr_done, irq_ack, es,
                 strobes_for(es), (i == 5), (i == 6));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic [1:0] ec, rem;
    logic       r, h, irq, take_irq, ok, exp_done, exp_ack;
    int         k;
    for (int n = 0; n < 40; n++) begin
      op = 8'($urandom); ec = 2'($urandom_range(0, 3)); take_irq = 1'b0;
      ok = 1'b0;
      for (int g = 0; g < 200 && !ok; g++) begin
        r = ($urandom_range(0, 2) != 0); h = ($urandom_range(0, 5) == 0);
        drive(r, h, 1'($urandom_range(0, 1)), (r && !h) ? op : 8'($urandom), 2'($urandom));
        total++;
        if (dbg_state !== ST_FETCH || {fetch, decode, execute, int_entry} !== 4'b1000 || instr_done !== 1'b0) begin
          bad++;
          $display("FAIL rnd_fetch n=%0d: state=%0d strobes=%b done=%b want state=2 strobes=1000 done=0",
                   n, dbg_state, {fetch, decode, execute, int_entry}, instr_done);
        end
        ok = r && !h;
      end
      if (!ok) begin total++; bad++; $display("FAIL rnd_fetch_timeout n=%0d: got no exit want exit", n); end
      ok = 1'b0;
      for (int g = 0; g < 200 && !ok; g++) begin
        h = ($urandom_range(0, 3) == 0);
        drive(1'($urandom_range(0, 1)), h, 1'($urandom_range(0, 1)), 8'($urandom), h ? 2'($urandom) : ec);
        total++;
        if (dbg_state !== ST_DECODE || decode !== 1'b1 || opcode_q !== op) begin
          bad++;
          $display("FAIL rnd_decode n=%0d: state=%0d opcode_q=%h want state=3 opcode_q=%h", n, dbg_state, opcode_q, op);
        end
        ok = !h;
      end
      if (!ok) begin total++; bad++; $display("FAIL rnd_decode_timeout n=%0d: got no exit want exit", n); end
      rem = ec; ok = 1'b0;
      for (int g = 0; g < 200 && !ok; g++) begin
        r = ($urandom_range(0, 2) != 0); h = ($urandom_range(0, 4) == 0); irq = 1'($urandom_range(0, 1));
        drive(r, h, irq, 8'($urandom), 2'($urandom));
        exp_done = r && !h && (rem == 2'd0);
        total++;
        if (dbg_state !== ST_EXEC || execute !== 1'b1 || cyc_left !== rem || instr_done !== exp_done || irq_ack !== 1'b0) begin
          bad++;
          $display("FAIL rnd_exec n=%0d: state=%0d cyc_left=%0d done=%b ack=%b want state=4 cyc_left=%0d done=%b ack=0",
                   n, dbg_state, cyc_left, instr_done, irq_ack, rem, exp_done);
        end
        if (r && !h) begin
          if (rem == 2'd0) begin ok = 1'b1; take_irq = irq; end
          else rem = rem - 2'd1;
        end
      end
      if (!ok) begin total++; bad++; $display("FAIL rnd_exec_timeout n=%0d: got no completion want completion", n); end
      if (NIRQ > 0 && take_irq) begin
        k = 0;
        for (int g = 0; g < 200 && k < NIRQ; g++) begin
          h = ($urandom_range(0, 3) == 0);
          drive(1'($urandom_range(0, 1)), h, 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom));
          exp_ack = !h && (k == 0);
          total++;
          if (dbg_state !== ST_IRQ || int_entry !== 1'b1 || irq_ack !== exp_ack || instr_done !== 1'b0) begin
            bad++;
            $display("FAIL rnd_irq n=%0d k=%0d: state=%0d int_entry=%b ack=%b done=%b want state=5 int_entry=1 ack=%b done=0",
                     n, k, dbg_state, int_entry, irq_ack, instr_done, exp_ack);
          end
          if (!h) k++;
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] exp_st [0:2];
    exp_st = '{ST_START, ST_INIT, ST_FETCH};
    drive(1'b1, 1'b0, 1'b0, 8'h11, 2'd3);
    drive(1'b1, 1'b0, 1'b0, 8'h11, 2'd3);
    drive(1'b1, 1'b0, 1'b0, 8'h11, 2'd3);
    total++;
    if (dbg_state !== ST_EXEC || cyc_left !== 2'd3) begin
      bad++; $display("FAIL areset_pre: state=%0d cyc_left=%0d want state=4 cyc_left=3", dbg_state, cyc_left);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (dbg_state !== ST_START ||
        {fetch, decode, execute, int_entry, irq_ack, instr_done, opcode_q, cyc_left} !== 16'h0) begin
      bad++;
      $display("FAIL areset_now: state=%0d strobes=%b ack=%b done=%b opcode_q=%h cyc_left=%0d want state=0 all 0",
               dbg_state, {fetch, decode, execute, int_entry}, irq_ack, instr_done, opcode_q, cyc_left);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) drive(1'b1, 1'b0, 1'b0, 8'h11, 2'd0);
      total++;
      if (dbg_state !== exp_st[i] || {fetch, decode, execute, int_entry} !== strobes_for(exp_st[i]) ||
          instr_done !== 1'b0) begin
        bad++;
        $display("FAIL areset_restart cyc%0d: state=%0d strobes=%b done=%b want state=%0d strobes=%b done=0",
                 i, dbg_state, {fetch, decode, execute, int_entry}, instr_done, exp_st[i], strobes_for(exp_st[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_exec();
    test_stall();
    test_irq();
    test_hold_irq();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
